// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit writing HI/LO.
// Optional macro MULTDIV_DIVZERO_EXC_EN: early exit with div_zero on a zero divisor.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [1:0]       o_dbg_state
);

    // Handshake: a start pulse is taken only in IDLE (start_mult wins over
    // start_div); busy stays high through the iterations, then done pulses for
    // one cycle with hi/lo valid, and the unit is idle again the cycle after.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // Booth datapath: {r_acc, r_mplr, r_qm1} is the 65-bit shift register
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mplr;
    logic               r_qm1;

    // Restoring divider datapath on operand magnitudes
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic               r_neg_q;
    logic               r_neg_r;
`ifdef MULTDIV_DIVZERO_EXC_EN
    logic               r_dz;
`endif

    logic               w_last;
    logic               w_busy;
    logic               w_done;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [1:0]         w_booth_sel;
    logic [WIDTH:0]     w_acc_ext;
    logic [WIDTH:0]     w_mcand_ext;
    logic [WIDTH:0]     w_booth_sum;
    logic [WIDTH:0]     w_rem_shift;
    logic [WIDTH-1:0]   w_rem_sub;
    logic               w_rem_ge;
    logic [WIDTH-1:0]   w_quo_final;
    logic [WIDTH-1:0]   w_rem_final;

    assign w_last  = (r_cnt == LAST_ITER);
    assign w_abs_a = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
    assign w_abs_b = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;

    // One extra accumulator bit keeps +|-2^31| representable before the shift
    assign w_booth_sel = {r_mplr[0], r_qm1};
    assign w_acc_ext   = {r_acc[WIDTH-1], r_acc};
    assign w_mcand_ext = {r_mcand[WIDTH-1], r_mcand};

    always_comb begin
        w_booth_sum = w_acc_ext;
        case (w_booth_sel)
            2'b01:   w_booth_sum = w_acc_ext + w_mcand_ext;
            2'b10:   w_booth_sum = w_acc_ext - w_mcand_ext;
            default: w_booth_sum = w_acc_ext;
        endcase
    end

    // Partial remainder is always below 2^WIDTH, so the subtract fits WIDTH bits
    assign w_rem_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_rem_ge    = (w_rem_shift >= {1'b0, r_divisor});
    assign w_rem_sub   = w_rem_shift[WIDTH-1:0] - r_divisor;
    assign w_quo_final = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    assign w_rem_final = r_neg_r ? (~r_rem + 1'b1) : r_rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_mult) begin
                    w_next_state = S_MULT;
                end else if (start_div) begin
                    w_next_state = S_DIV;
                end
            end
            S_MULT: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DIV: begin
                w_busy = 1'b1;
`ifdef MULTDIV_DIVZERO_EXC_EN
                if (r_dz || w_last) begin
                    w_next_state = S_DONE;
                end
`else
                if (w_last) begin
                    w_next_state = S_DONE;
                end
`endif
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_mplr    <= '0;
            r_qm1     <= 1'b0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
`ifdef MULTDIV_DIVZERO_EXC_EN
            r_dz      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (start_mult) begin
                        r_mcand <= op_a;
                        r_acc   <= '0;
                        r_mplr  <= op_b;
                        r_qm1   <= 1'b0;
`ifdef MULTDIV_DIVZERO_EXC_EN
                        r_dz    <= 1'b0;
`endif
                    end else if (start_div) begin
                        r_divisor <= w_abs_b;
                        r_quo     <= w_abs_a;
                        r_rem     <= '0;
                        r_neg_q   <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        r_neg_r   <= op_a[WIDTH-1];
`ifdef MULTDIV_DIVZERO_EXC_EN
                        r_dz      <= (op_b == '0);
`endif
                    end
                end
                S_MULT: begin
                    if (w_last) begin
                        r_hi <= r_acc;
                        r_lo <= r_mplr;
                    end else begin
                        r_acc  <= w_booth_sum[WIDTH:1];
                        r_mplr <= {w_booth_sum[0], r_mplr[WIDTH-1:1]};
                        r_qm1  <= r_mplr[0];
                        r_cnt  <= r_cnt + CNT_ONE;
                    end
                end
                S_DIV: begin
`ifdef MULTDIV_DIVZERO_EXC_EN
                    if (r_dz) begin
                        r_cnt <= r_cnt;
                    end else
`endif
                    if (w_last) begin
                        r_hi <= w_rem_final;
                        r_lo <= w_quo_final;
                    end else begin
                        r_rem <= w_rem_ge ? w_rem_sub : w_rem_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], w_rem_ge};
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign hi          = r_hi;
    assign lo          = r_lo;
    assign busy        = w_busy;
    assign done        = w_done;
    assign o_dbg_state = r_state;
`ifdef MULTDIV_DIVZERO_EXC_EN
    assign div_zero    = w_done & r_dz;
`else
    assign div_zero    = 1'b0;
`endif

endmodule
